store_buffer: RTL and testbench

- Responder end of the rename-stage store allocation interface.
- Hands out up to 4 in-order Store Buffer (SB) entry IDs per cycle and captures address/data/byte-enable from the LSU.
- Marks entries committed on ROB retirement and drains committed stores to the D-cache in program order.
- Sits between rename, LSU, ROB commit and the D-cache write port; discards speculative entries on flush.

---
 rtl/sb_pkg.sv | 28 ++
 rtl/store_buffer.sv | 149 ++++++++++++++
 tb/tb_store_buffer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Store buffer shared types: entry state encoding, entry record,
// data-path widths and the lane popcount helper.
package sb_pkg;

    localparam int PLEN  = 32;
    localparam int XLEN  = 32;
    localparam int BEW   = XLEN / 8;
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SB_FREE,
        SB_ALLOC,
        SB_FILLED,
        SB_COMMITTED
    } sb_state_e;

    typedef struct packed {
        sb_state_e        state;
        logic [PLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [BEW-1:0]   be;
    } sb_entry_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/store_buffer.sv
// In-order store buffer: allocates IDs at rename, captures LSU fills,
// marks ROB commits and drains committed stores to the D-cache.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   alloc_req_i/alloc_en_i -> alloc_ready_o, alloc_id_o  (rename side)
//   fill_valid_i, fill_sb_id_i, fill_addr_i/data_i/be_i (LSU side)
//   commit_valid_i, commit_sb_id_i                      (ROB side)
//   dc_req_valid_o/ready_i, dc_req_addr/data/be_o       (D-cache side)
//   empty_o                                              (status)
module store_buffer
    import sb_pkg::*;
#(
    parameter int SB_DEPTH     = 16,
    parameter int SB_IDX_WIDTH = $clog2(SB_DEPTH)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [LANES-1:0]                   alloc_req_i,
    input  logic                               alloc_en_i,
    output logic                               alloc_ready_o,
    output logic [LANES-1:0][SB_IDX_WIDTH-1:0] alloc_id_o,
    input  logic                               fill_valid_i,
    input  logic [SB_IDX_WIDTH-1:0]            fill_sb_id_i,
    input  logic [PLEN-1:0]                    fill_addr_i,
    input  logic [XLEN-1:0]                    fill_data_i,
    input  logic [BEW-1:0]                     fill_be_i,
    input  logic [LANES-1:0]                   commit_valid_i,
    input  logic [LANES-1:0][SB_IDX_WIDTH-1:0] commit_sb_id_i,
    output logic                               dc_req_valid_o,
    input  logic                               dc_req_ready_i,
    output logic [PLEN-1:0]                    dc_req_addr_o,
    output logic [XLEN-1:0]                    dc_req_data_o,
    output logic [BEW-1:0]                     dc_req_be_o,
    output logic                               empty_o
);

    localparam int PTRW = SB_IDX_WIDTH + 1;

    sb_entry_t                 sb_q [SB_DEPTH];
    sb_state_e                 st_d [SB_DEPTH];
    logic [PTRW-1:0]           head_q, tail_q, head_d, tail_d;
    logic [PTRW-1:0]           count, ncomm;
    logic [PTRW:0]             free_cnt;
    logic [2:0]                n_req;
    logic [SB_IDX_WIDTH-1:0]   head_idx, k;
    logic                      alloc_fire, fill_ok, drain;

    // Occupancy comes from registered pointers only, so a slot freed by
    // this cycle's drain is not offered to rename until next cycle.
    assign count    = tail_q - head_q;
    assign free_cnt = (PTRW+1)'(SB_DEPTH) - (PTRW+1)'(count);
    assign n_req    = popcnt4(alloc_req_i);
    assign alloc_ready_o = (PTRW+1)'(n_req) <= free_cnt;
    assign empty_o  = (count == '0);

    assign alloc_fire = alloc_en_i && alloc_ready_o && !flush_i;
    assign fill_ok    = fill_valid_i && !flush_i
                        && (sb_q[fill_sb_id_i].state == SB_ALLOC);

    assign head_idx       = head_q[SB_IDX_WIDTH-1:0];
    assign dc_req_valid_o = (sb_q[head_idx].state == SB_COMMITTED);
    assign dc_req_addr_o  = sb_q[head_idx].addr;
    assign dc_req_data_o  = sb_q[head_idx].data;
    assign dc_req_be_o    = sb_q[head_idx].be;
    assign drain          = dc_req_valid_o && dc_req_ready_i;

    // k-th requesting lane gets tail + k.
    always_comb begin
        k = '0;
        for (int l = 0; l < LANES; l++) begin
            alloc_id_o[l] = '0;
            if (alloc_req_i[l]) begin
                alloc_id_o[l] = tail_q[SB_IDX_WIDTH-1:0] + k;
                k = k + SB_IDX_WIDTH'(1);
            end
        end
    end

    // Commits are applied before the flush so a store retiring in the
    // flush cycle survives it.
    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) st_d[i] = sb_q[i].state;
        for (int l = 0; l < LANES; l++) begin
            if (commit_valid_i[l]
                && sb_q[commit_sb_id_i[l]].state == SB_FILLED)
                st_d[commit_sb_id_i[l]] = SB_COMMITTED;
        end
        if (drain) st_d[head_idx] = SB_FREE;
        if (flush_i) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (st_d[i] == SB_ALLOC || st_d[i] == SB_FILLED)
                    st_d[i] = SB_FREE;
            end
        end else begin
            if (fill_ok) st_d[fill_sb_id_i] = SB_FILLED;
            if (alloc_fire) begin
                for (int l = 0; l < LANES; l++) begin
                    if (alloc_req_i[l]) st_d[alloc_id_o[l]] = SB_ALLOC;
                end
            end
        end
    end

    always_comb begin
        ncomm = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (st_d[i] == SB_COMMITTED) ncomm = ncomm + PTRW'(1);
        end
    end

    // Committed entries are contiguous from head, so a flush rewinds
    // tail to just past the last surviving committed store.
    always_comb begin
        head_d = head_q + PTRW'(drain);
        tail_d = tail_q;
        if (flush_i)         tail_d = head_d + ncomm;
        else if (alloc_fire) tail_d = tail_q + PTRW'(n_req);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < SB_DEPTH; i++) sb_q[i].state <= st_d[i];
            if (fill_ok) begin
                sb_q[fill_sb_id_i].addr <= fill_addr_i;
                sb_q[fill_sb_id_i].data <= fill_data_i;
                sb_q[fill_sb_id_i].be   <= fill_be_i;
            end
        end
    end

    // Protocol checks: fills target allocated entries, commits target
    // filled entries.
    always @(posedge clk_i) begin
        if (!rst_i && fill_valid_i)
            assert (sb_q[fill_sb_id_i].state == SB_ALLOC);
        for (int l = 0; l < LANES; l++) begin
            if (!rst_i && commit_valid_i[l])
                assert (sb_q[commit_sb_id_i[l]].state == SB_FILLED);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: allocation, fill,
// commit, drain back-pressure, full, flush, reset and ID wrap.
module tb_store_buffer;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic [3:0]       alloc_req_i;
    logic             alloc_en_i;
    logic             alloc_ready_o;
    logic [3:0][3:0]  alloc_id_o;
    logic             fill_valid_i;
    logic [3:0]       fill_sb_id_i;
    logic [31:0]      fill_addr_i;
    logic [31:0]      fill_data_i;
    logic [3:0]       fill_be_i;
    logic [3:0]       commit_valid_i;
    logic [3:0][3:0]  commit_sb_id_i;
    logic             dc_req_valid_o;
    logic             dc_req_ready_i;
    logic [31:0]      dc_req_addr_o;
    logic [31:0]      dc_req_data_o;
    logic [3:0]       dc_req_be_o;
    logic             empty_o;

    int passed = 0;
    int total  = 0;

    store_buffer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .alloc_req_i    (alloc_req_i),
        .alloc_en_i     (alloc_en_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_id_o     (alloc_id_o),
        .fill_valid_i   (fill_valid_i),
        .fill_sb_id_i   (fill_sb_id_i),
        .fill_addr_i    (fill_addr_i),
        .fill_data_i    (fill_data_i),
        .fill_be_i      (fill_be_i),
        .commit_valid_i (commit_valid_i),
        .commit_sb_id_i (commit_sb_id_i),
        .dc_req_valid_o (dc_req_valid_o),
        .dc_req_ready_i (dc_req_ready_i),
        .dc_req_addr_o  (dc_req_addr_o),
        .dc_req_data_o  (dc_req_data_o),
        .dc_req_be_o    (dc_req_be_o),
        .empty_o        (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic idle;
        flush_i        = 1'b0;
        alloc_req_i    = '0;
        alloc_en_i     = 1'b0;
        fill_valid_i   = 1'b0;
        fill_sb_id_i   = '0;
        fill_addr_i    = '0;
        fill_data_i    = '0;
        fill_be_i      = '0;
        commit_valid_i = '0;
        commit_sb_id_i = '0;
        dc_req_ready_i = 1'b0;
    endtask

    // Inputs change 1 ns after the rising edge; checks 1 ns later.
    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] req);
        alloc_req_i = req;
        alloc_en_i  = 1'b1;
        step();
        idle();
    endtask

    task automatic fill(input logic [3:0] id, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        fill_valid_i = 1'b1;
        fill_sb_id_i = id;
        fill_addr_i  = a;
        fill_data_i  = d;
        fill_be_i    = be;
        step();
        idle();
    endtask

    task automatic commit1(input logic [3:0] id);
        commit_valid_i    = 4'b0001;
        commit_sb_id_i[0] = id;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        step();
        step();
        // Reset state
        chk("rst_empty", empty_o, 1);
        chk("rst_ready", alloc_ready_o, 1);
        chk("rst_dc_valid", dc_req_valid_o, 0);
        chk("rst_alloc_id", alloc_id_o, 0);
        chk("rst_dc_addr", dc_req_addr_o, 0);
        chk("rst_dc_data_be", {dc_req_data_o, dc_req_be_o}, 0);
        rst_i = 1'b0;
        step();

        // Two-lane allocation on lanes 1 and 3
        alloc_req_i = 4'b1010;
        alloc_en_i  = 1'b1;
        settle();
        chk("a1010_ready", alloc_ready_o, 1);
        chk("a1010_ids", alloc_id_o, 16'h1000);
        step();
        idle();
        alloc_req_i = 4'b0001;
        settle();
        chk("a1010_empty", empty_o, 0);
        chk("a1010_tail", alloc_id_o[0], 2);
        idle();

        // Fill, commit, back-pressured drain of ID0
        fill(4'd0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        commit1(4'd0);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("stall_valid", dc_req_valid_o, 1);
            chk("stall_addr", dc_req_addr_o, 32'h8000_0010);
            chk("stall_data_be", {dc_req_data_o, dc_req_be_o},
                36'hDEAD_BEEF_F);
            step();
        end
        dc_req_ready_i = 1'b1;
        settle();
        chk("hs_valid", dc_req_valid_o, 1);
        step();
        idle();
        settle();
        chk("post_hs_valid", dc_req_valid_o, 0);
        chk("post_hs_empty", empty_o, 0);

        // Full buffer, then one drain frees a slot a cycle later
        do_reset();
        alloc(4'b1111);
        alloc(4'b1111);
        alloc(4'b1111);
        alloc_req_i = 4'b1111;
        alloc_en_i  = 1'b1;
        settle();
        chk("fill16_ids", alloc_id_o, 16'hFEDC);
        step();
        idle();
        alloc_req_i = 4'b0001;
        settle();
        chk("full_ready", alloc_ready_o, 0);
        alloc_req_i = 4'b0000;
        settle();
        chk("full_zero_req", alloc_ready_o, 1);
        fill(4'd0, 32'h0000_0040, 32'h1111_2222, 4'h3);
        commit1(4'd0);
        alloc_req_i    = 4'b0001;
        dc_req_ready_i = 1'b1;
        settle();
        chk("full_drain_valid", dc_req_valid_o, 1);
        chk("full_drain_ready", alloc_ready_o, 0);
        step();
        idle();
        alloc_req_i = 4'b0001;
        settle();
        chk("after_drain_ready", alloc_ready_o, 1);
        chk("after_drain_id", alloc_id_o[0], 0);
        idle();

        // Flush with 0-1 committed and 2-5 filled
        do_reset();
        alloc(4'b1111);
        alloc(4'b0011);
        for (int i = 0; i < 6; i++)
            fill(4'(i), 32'h1000 + 32'(i * 4), 32'h100 + 32'(i), 4'hF);
        commit_valid_i    = 4'b0011;
        commit_sb_id_i[0] = 4'd0;
        commit_sb_id_i[1] = 4'd1;
        step();
        idle();
        flush_i = 1'b1;
        step();
        idle();
        alloc_req_i = 4'b0001;
        settle();
        chk("flush_tail", alloc_id_o[0], 2);
        idle();
        dc_req_ready_i = 1'b1;
        settle();
        chk("flush_d0", {dc_req_valid_o, dc_req_addr_o}, 33'h1_0000_1000);
        step();
        chk("flush_d1", {dc_req_valid_o, dc_req_addr_o}, 33'h1_0000_1004);
        step();
        idle();
        settle();
        chk("flush_d2_none", dc_req_valid_o, 0);
        chk("flush_empty", empty_o, 1);
        alloc_req_i = 4'b0001;
        alloc_en_i  = 1'b1;
        settle();
        chk("flush_next_id", alloc_id_o[0], 2);
        step();
        idle();

        // Flush coinciding with commit of ID2 and an allocation
        do_reset();
        alloc(4'b0111);
        for (int i = 0; i < 3; i++)
            fill(4'(i), 32'h2000 + 32'(i * 4), 32'h200 + 32'(i), 4'hF);
        commit_valid_i    = 4'b0011;
        commit_sb_id_i[0] = 4'd0;
        commit_sb_id_i[1] = 4'd1;
        step();
        idle();
        flush_i           = 1'b1;
        commit_valid_i    = 4'b0001;
        commit_sb_id_i[0] = 4'd2;
        alloc_req_i       = 4'b0001;
        alloc_en_i        = 1'b1;
        step();
        idle();
        alloc_req_i = 4'b0001;
        settle();
        chk("fc_tail", alloc_id_o[0], 3);
        idle();
        dc_req_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("fc_drain", {dc_req_valid_o, dc_req_addr_o},
                {1'b1, 32'h2000 + 32'(i * 4)});
            step();
        end
        idle();
        settle();
        chk("fc_done_valid", dc_req_valid_o, 0);
        chk("fc_done_empty", empty_o, 1);

        // Reset asserted while a drain request is pending
        do_reset();
        alloc(4'b0001);
        fill(4'd0, 32'h3000, 32'h3333, 4'h1);
        commit1(4'd0);
        settle();
        chk("midrst_pre", dc_req_valid_o, 1);
        rst_i = 1'b1;
        settle();
        chk("midrst_valid", dc_req_valid_o, 0);
        chk("midrst_empty", empty_o, 1);
        step();
        rst_i = 1'b0;
        step();

        // 40 single-store round trips across the ID wrap
        for (int i = 0; i < 40; i++) begin
            alloc_req_i = 4'b0001;
            alloc_en_i  = 1'b1;
            settle();
            chk("wrap_id", alloc_id_o[0], 64'(i % 16));
            step();
            idle();
            fill(4'(i % 16), 32'h4000_0000 + 32'(i * 4),
                 32'hA500_0000 | 32'(i), 4'hF);
            commit1(4'(i % 16));
            dc_req_ready_i = 1'b1;
            settle();
            chk("wrap_drain", {dc_req_valid_o, dc_req_data_o},
                {1'b1, 32'hA500_0000 | 32'(i)});
            step();
            idle();
        end
        settle();
        chk("wrap_empty", empty_o, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
